// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 codes, FSM state type and load extension shared by dmem_lsu_port
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (funct3)
            F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
            F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
            F3_W:    load_extend = sh;
            F3_BU:   load_extend = {24'd0, sh[7:0]};
            F3_HU:   load_extend = {16'd0, sh[15:0]};
            default: load_extend = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane selection for stores and loads, error detection
// Misaligned H/W accesses trap when DMEM_MISALIGN_TRAP_EN is defined, else low bits are dropped.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        err
);

    logic [1:0] eff_off;
    logic       bad_f3;

    always_comb begin
        eff_off = off;
        case (funct3[1:0])
            2'b01:   eff_off = {off[1], 1'b0};
            2'b10:   eff_off = 2'b00;
            default: eff_off = off;
        endcase

        // 011, 11x, and the unsigned codes used as stores have no meaning
        bad_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        err = bad_f3 || ((funct3[1:0] == 2'b01) && off[0]) ||
              ((funct3[1:0] == 2'b10) && (off != 2'b00));
`else
        err = bad_f3;
`endif

        be    = 4'b0000;
        wword = 32'd0;
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                case (funct3[1:0])
                    2'b00: begin
                        be    = 4'b0001 << eff_off;
                        wword = {4{wdata[7:0]}};
                    end
                    2'b01: begin
                        be    = 4'b0011 << eff_off;
                        wword = {2{wdata[15:0]}};
                    end
                    default: begin
                        be    = 4'b1111;
                        wword = wdata;
                    end
                endcase
            end else begin
                rdata = load_extend(rword, funct3, eff_off);
            end
        end
    end

endmodule

// File: rtl/dmem_lsu_port.sv
// rtl/dmem_lsu_port.sv - RV32I byte-addressed data memory with latency, clear sweep and req/rsp port
// Optional misaligned-access trap: DMEM_MISALIGN_TRAP_EN.
module dmem_lsu_port
    import dmem_pkg::*;
#(
    parameter  int DEPTH   = 256,
    parameter  int LATENCY = 1,
    localparam int AW      = $clog2(DEPTH) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          busy
);

    localparam int         IW       = $clog2(DEPTH);
    localparam logic [2:0] LAT_LAST = 3'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_t        state;
    logic [2:0]    lat_cnt;
    logic [IW-1:0] clr_cnt;
    logic          l_we;
    logic [2:0]    l_f3;
    logic [AW-1:0] l_addr;
    logic [31:0]   l_wdata;
    logic [31:0]   mem [DEPTH];

    logic          a_we;
    logic [2:0]    a_f3;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata;
    logic [IW-1:0] a_idx;
    logic [3:0]    a_be;
    logic [31:0]   a_wword;
    logic [31:0]   a_rdata;
    logic          a_err;
    logic          fire;

    // With zero latency the access happens on the accept edge, before the latch holds the request
    assign a_we    = (state == ST_IDLE) ? req_we     : l_we;
    assign a_f3    = (state == ST_IDLE) ? req_funct3 : l_f3;
    assign a_addr  = (state == ST_IDLE) ? req_addr   : l_addr;
    assign a_wdata = (state == ST_IDLE) ? req_wdata  : l_wdata;
    assign a_idx   = a_addr[AW-1:2];

    assign fire = ((state == ST_IDLE) && req_valid && req_ready && (LATENCY == 0)) ||
                  ((state == ST_WAIT) && (lat_cnt == LAT_LAST));

    dmem_lane_align u_align (
        .we     (a_we),
        .funct3 (a_f3),
        .off    (a_addr[1:0]),
        .wdata  (a_wdata),
        .rword  (mem[a_idx]),
        .be     (a_be),
        .wword  (a_wword),
        .rdata  (a_rdata),
        .err    (a_err)
    );

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= 32'd0;
        end else if (fire && a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            lat_cnt   <= 3'd0;
            l_we      <= 1'b0;
            l_f3      <= 3'd0;
            l_addr    <= '0;
            l_wdata   <= 32'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == IW'(DEPTH - 1)) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        l_we      <= req_we;
                        l_f3      <= req_funct3;
                        l_addr    <= req_addr;
                        l_wdata   <= req_wdata;
                        lat_cnt   <= 3'd0;
                        req_ready <= 1'b0;
                        if (fire) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= a_rdata;
                            rsp_err   <= a_err;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (fire) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= a_rdata;
                        rsp_err   <= a_err;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_port.sv
// tb/tb_dmem_lsu_port.sv - self-checking bench for dmem_lsu_port against a byte-array model
module tb_dmem_lsu_port;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int AW      = $clog2(DEPTH) + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'd0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [DEPTH*4];
    logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    always #5 clk = ~clk;

    dmem_lsu_port #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic model_clear();
        foreach (mdl[i]) mdl[i] = 8'h00;
    endtask

    // Memory as a flat byte array: accesses cover `size` bytes at the size-aligned base
    task automatic model_op(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
        int size;
        int base;
        bit legal;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        legal = (size != 0) && !(we && f3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (legal && (a % size) != 0) legal = 0;
`endif
        rd = 32'd0;
        er = !legal;
        if (legal) begin
            base = a - (a % size);
            if (we) begin
                for (int i = 0; i < size; i++) mdl[base+i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[base+i];
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
                rd = v;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd  = 'x;
        er  = 'x;
        lat = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = AW'(a);
        req_wdata  = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 1;
        #1 req_valid = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (rsp_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
            return;
        end
        repeat (hold) @(posedge clk);
        #1;
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic er;
        int lat;
        int bad;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b busy=%b required 0 0 0 0 1",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy !== 1'b1 || req_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sweep_busy: %0d cycles not busy, required 0", bad);
        end
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done: ready=%b busy=%b required 1 0", req_ready, busy);
        end
        do_req(1'b0, 3'd2, 'h3FC, 32'd0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL lw_3fc_after_clear: rdata=%h err=%b required 00000000 0", rd, er);
        end
    endtask

    task automatic test_load_extend();
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        int          ads [4] = '{3, 3, 2, 0};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        do_req(1'b1, 3'd2, 'h000, 32'hDEADBEEF, 0, rd, er, lat);
        model_op(1'b1, 3'd2, 'h000, 32'hDEADBEEF, mrd, mer);
        checks++;
        if (lat !== LATENCY + 1) begin
            errors++;
            $display("FAIL sw_latency: %0d cycles, required %0d", lat, LATENCY + 1);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3s[i], ads[i], 32'd0, 0, rd, er, lat);
            checks++;
            if (rd !== exp[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL load_ext_%0d: rdata=%h err=%b required %h 0", i, rd, er, exp[i]);
            end
            checks++;
            if (lat !== LATENCY + 1) begin
                errors++;
                $display("FAIL load_latency_%0d: %0d cycles, required %0d", i, lat, LATENCY + 1);
            end
        end
    endtask

    task automatic test_lane_merge();
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        do_req(1'b1, 3'd2, 'h004, 32'h11111111, 0, rd, er, lat);
        model_op(1'b1, 3'd2, 'h004, 32'h11111111, mrd, mer);
        do_req(1'b1, 3'd0, 'h005, 32'h12345678, 1, rd, er, lat);
        model_op(1'b1, 3'd0, 'h005, 32'h12345678, mrd, mer);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL store_rsp: rdata=%h err=%b required 00000000 0", rd, er);
        end
        do_req(1'b0, 3'd2, 'h004, 32'd0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'h11117811) begin
            errors++;
            $display("FAIL sb_merge: rdata=%h required 11117811", rd);
        end
        do_req(1'b1, 3'd1, 'h006, 32'h0000ABCD, 0, rd, er, lat);
        model_op(1'b1, 3'd1, 'h006, 32'h0000ABCD, mrd, mer);
        do_req(1'b0, 3'd2, 'h004, 32'd0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'hABCD7811) begin
            errors++;
            $display("FAIL sh_merge: rdata=%h required ABCD7811", rd);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = AW'('h004);
        n = 0;
        while (req_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_addr = AW'('h000);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hABCD7811 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b rdata=%h ready=%b required 1 ABCD7811 0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_rsp_hs: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || n !== LATENCY) begin
            errors++;
            $display("FAIL second_req: valid=%b rdata=%h wait=%0d required 1 DEADBEEF %0d",
                     rsp_valid, rsp_rdata, n, LATENCY);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_misalign();
        logic [31:0] rd, mrd, exp_word;
        logic er, mer, exp_err;
        int lat;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_err  = 1'b1;
        exp_word = 32'hABCD7811;
`else
        exp_err  = 1'b0;
        exp_word = 32'hCAFEF00D;
`endif
        do_req(1'b1, 3'd2, 'h006, 32'hCAFEF00D, 0, rd, er, lat);
        model_op(1'b1, 3'd2, 'h006, 32'hCAFEF00D, mrd, mer);
        checks++;
        if (er !== exp_err || rd !== 32'd0) begin
            errors++;
            $display("FAIL misaligned_sw: err=%b rdata=%h required %b 00000000", er, rd, exp_err);
        end
        do_req(1'b0, 3'd2, 'h004, 32'd0, 0, rd, er, lat);
        checks++;
        if (rd !== exp_word) begin
            errors++;
            $display("FAIL misaligned_word: rdata=%h required %h", rd, exp_word);
        end
        do_req(1'b0, 3'd3, 'h004, 32'd0, 0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL f3_011: err=%b rdata=%h required 1 00000000", er, rd);
        end
        do_req(1'b1, 3'd4, 'h004, 32'h000000FF, 0, rd, er, lat);
        do_req(1'b0, 3'd2, 'h004, 32'd0, 0, rd, mer, lat);
        checks++;
        if (er !== 1'b1 || rd !== exp_word) begin
            errors++;
            $display("FAIL store_bu: err=%b word=%h required 1 %h", er, rd, exp_word);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd;
        logic er;
        int lat;
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = AW'('h008);
        req_wdata  = 32'h55AA55AA;
        n = 0;
        while (req_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait: valid=%b busy=%b ready=%b required 0 1 0", rsp_valid, busy, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        do_req(1'b0, 3'd2, 'h008, 32'd0, 0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL dropped_store: rdata=%h err=%b required 00000000 0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, wd;
        logic er, mer, we;
        logic [2:0] f3;
        int a, lat;
        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH*4 - 1)) : int'($urandom_range(0, 31));
            wd = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(we, f3, a, wd, int'($urandom_range(0, 3)), rd, er, lat);
            model_op(we, f3, a, wd, mrd, mer);
            checks++;
            if (rd !== mrd || er !== mer) begin
                errors++;
                $display("FAIL random_%0d we=%b f3=%0d addr=%h: rdata=%h err=%b required %h %b",
                         k, we, f3, a, rd, er, mrd, mer);
            end
            checks++;
            if (lat !== LATENCY + 1) begin
                errors++;
                $display("FAIL random_latency_%0d: %0d cycles, required %0d", k, lat, LATENCY + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_extend();
        test_lane_merge();
        test_backpressure();
        test_misalign();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
